// File: rtl/led_pattern_engine.sv
// led_pattern_engine
// Tick generator plus a 4-mode pattern engine (SHIFT, FLASH, BOUNCE, FILL)
// driving an NB_LEDS-wide RGB LED bank.
//
// Ports:
//   clock     system clock
//   i_reset   synchronous, active-high reset
//   i_sw      [0] run enable, [2:1] speed select, [3] direction (0 toward MSB)
//   i_button  [0] next mode, [1] red, [2] green, [3] blue
//   o_leds    [0] mode-press toggle, [3:1] one-hot colour {blue, green, red}
//   o_led_r/g/b  colour channels; the selected one carries the pattern
//   o_mode    current mode (0 SHIFT, 1 FLASH, 2 BOUNCE, 3 FILL)
//   o_tick    single-cycle step strobe
//
// Build option: define LED_PATTERN_BUTTON_SYNC_EN to pass i_button through a
// 2-flop synchronizer before edge detection (press effect after 3 edges
// instead of 1).
module led_pattern_engine #(
  parameter int          NB_LEDS    = 4,
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_0    = 2**22-1,
  parameter int unsigned LIMIT_1    = 2**23-1,
  parameter int unsigned LIMIT_2    = 2**24-1,
  parameter int unsigned LIMIT_3    = 2**25-1
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [3:0]         i_sw,
  input  logic [3:0]         i_button,
  output logic [3:0]         o_leds,
  output logic [NB_LEDS-1:0] o_led_r,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic [1:0]         o_mode,
  output logic               o_tick
);

  typedef enum logic [1:0] {SHIFT, FLASH, BOUNCE, FILL} mode_t;

  localparam logic [NB_LEDS-1:0] PAT_ONE  = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] PAT_ONES = '1;

  // ---------------- tick generator ----------------
  logic [NB_COUNTER-1:0] cnt, cnt_next, limit_sel;
  logic                  tick;

  always_comb begin
    case (i_sw[2:1])
      2'd0:    limit_sel = NB_COUNTER'(LIMIT_0);
      2'd1:    limit_sel = NB_COUNTER'(LIMIT_1);
      2'd2:    limit_sel = NB_COUNTER'(LIMIT_2);
      default: limit_sel = NB_COUNTER'(LIMIT_3);
    endcase
  end

  // >= rather than == so that lowering the speed limit mid-count never
  // strands the counter above the new terminal count.
  assign tick = i_sw[0] && (cnt >= limit_sel);

  // ---------------- button edge detection ----------------
  logic [3:0] btn_src, button_d, press;

`ifdef LED_PATTERN_BUTTON_SYNC_EN
  logic [3:0] btn_meta, btn_sync;
  always_ff @(posedge clock) begin
    if (i_reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= i_button;
      btn_sync <= btn_meta;
    end
  end
  assign btn_src = btn_sync;
`else
  assign btn_src = i_button;
`endif

  assign press = btn_src & ~button_d;

  // ---------------- pattern / mode state ----------------
  mode_t              mode, mode_next;
  logic [NB_LEDS-1:0] pattern, pattern_next;
  logic               bounce_up, bounce_up_next;
  logic [2:0]         colour, colour_next;   // {blue, green, red}
  logic               mode_tgl, mode_tgl_next;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      cnt       <= '0;
      button_d  <= '0;
      mode      <= SHIFT;
      pattern   <= PAT_ONE;
      bounce_up <= 1'b1;
      colour    <= 3'b001;
      mode_tgl  <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      button_d  <= btn_src;
      mode      <= mode_next;
      pattern   <= pattern_next;
      bounce_up <= bounce_up_next;
      colour    <= colour_next;
      mode_tgl  <= mode_tgl_next;
    end
  end

  always_comb begin
    cnt_next       = cnt;
    mode_next      = mode;
    pattern_next   = pattern;
    bounce_up_next = bounce_up;
    colour_next    = colour;
    mode_tgl_next  = mode_tgl;

    if (tick)          cnt_next = '0;
    else if (i_sw[0])  cnt_next = cnt + 1'b1;

    if (press[0]) begin
      // Mode change reseeds the pattern; a coincident tick is dropped.
      mode_next      = mode_t'(mode + 2'd1);
      mode_tgl_next  = ~mode_tgl;
      bounce_up_next = 1'b1;
      case (mode_next)
        FLASH:   pattern_next = PAT_ONES;
        FILL:    pattern_next = '0;
        default: pattern_next = PAT_ONE;
      endcase
    end else if (tick) begin
      case (mode)
        SHIFT: pattern_next = i_sw[3] ? {pattern[0], pattern[NB_LEDS-1:1]}
                                      : {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
        FLASH: pattern_next = ~pattern;
        BOUNCE: begin
          // Direction switch and the reverse step happen on the same tick,
          // so the end LED is lit for exactly one step.
          if (bounce_up) begin
            if (pattern[NB_LEDS-1]) begin
              pattern_next   = pattern >> 1;
              bounce_up_next = 1'b0;
            end else begin
              pattern_next = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              pattern_next   = pattern << 1;
              bounce_up_next = 1'b1;
            end else begin
              pattern_next = pattern >> 1;
            end
          end
        end
        default: begin  // FILL
          if (&pattern)     pattern_next = '0;
          else if (i_sw[3]) pattern_next = {1'b1, pattern[NB_LEDS-1:1]};
          else              pattern_next = {pattern[NB_LEDS-2:0], 1'b1};
        end
      endcase
    end

    if (press[1])      colour_next = 3'b001;
    else if (press[2]) colour_next = 3'b010;
    else if (press[3]) colour_next = 3'b100;
  end

  // ---------------- outputs ----------------
  assign o_tick  = tick;
  assign o_mode  = mode;
  assign o_leds  = {colour, mode_tgl};
  assign o_led_r = colour[0] ? pattern : '0;
  assign o_led_g = colour[1] ? pattern : '0;
  assign o_led_b = colour[2] ? pattern : '0;

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

  logic       clock = 1'b0;
  logic       i_reset;
  logic [3:0] i_sw, i_button;
  logic [3:0] o_leds, o_led_r, o_led_g, o_led_b;
  logic [1:0] o_mode;
  logic       o_tick;

  always #5 clock = ~clock;

  led_pattern_engine #(
    .NB_LEDS(4), .NB_COUNTER(32),
    .LIMIT_0(3), .LIMIT_1(7), .LIMIT_2(15), .LIMIT_3(31)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_sw(i_sw), .i_button(i_button),
    .o_leds(o_leds), .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b),
    .o_mode(o_mode), .o_tick(o_tick)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (integer arithmetic, N = 4) ----------------
  int lim[4] = '{3, 7, 15, 31};
  int m_cnt = 0, m_mode = 0, m_pat = 1, m_up = 1, m_col = 0, m_tog = 0;
  logic [3:0] m_bprev = '0, m_s1 = '0, m_s2 = '0;

  function automatic int seed(int md);
    case (md)
      1:       return 15;
      3:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic logic m_tick();
    return i_sw[0] && (m_cnt >= lim[i_sw[2:1]]);
  endfunction

  function automatic logic [18:0] exp_vec();
    logic [3:0] p;
    logic [2:0] c;
    p = 4'(m_pat);
    c = 3'(1 << m_col);
    return {c, 1'(m_tog), (m_col == 0) ? p : 4'b0, (m_col == 1) ? p : 4'b0,
            (m_col == 2) ? p : 4'b0, 2'(m_mode), m_tick()};
  endfunction

  wire [18:0] dut_vec = {o_leds, o_led_r, o_led_g, o_led_b, o_mode, o_tick};

  task automatic step_pattern();
    case (m_mode)
      0: m_pat = i_sw[3] ? (m_pat / 2 + (m_pat % 2) * 8) : ((m_pat * 2) % 16 + m_pat / 8);
      1: m_pat = 15 - m_pat;
      2: if (m_up != 0) begin
           if (m_pat == 8) begin m_pat = 4; m_up = 0; end else m_pat = m_pat * 2;
         end else begin
           if (m_pat == 1) begin m_pat = 2; m_up = 1; end else m_pat = m_pat / 2;
         end
      default: if (m_pat == 15) m_pat = 0;
               else m_pat = i_sw[3] ? (m_pat / 2 + 8) : ((m_pat * 2 + 1) % 16);
    endcase
  endtask

  task automatic model_edge();
    logic t;
    logic [3:0] src, pr;
    t = m_tick();
    if (i_reset) begin
      m_cnt = 0; m_mode = 0; m_pat = 1; m_up = 1; m_col = 0; m_tog = 0;
      m_bprev = '0; m_s1 = '0; m_s2 = '0;
    end else begin
`ifdef LED_PATTERN_BUTTON_SYNC_EN
      src = m_s2; m_s2 = m_s1; m_s1 = i_button;
`else
      src = i_button;
`endif
      pr = src & ~m_bprev;
      m_bprev = src;
      if (t) m_cnt = 0; else if (i_sw[0]) m_cnt = m_cnt + 1;
      if (pr[0]) begin
        m_mode = (m_mode + 1) % 4; m_tog = 1 - m_tog; m_pat = seed(m_mode); m_up = 1;
      end else if (t) step_pattern();
      if (pr[1]) m_col = 0; else if (pr[2]) m_col = 1; else if (pr[3]) m_col = 2;
    end
  endtask

  // Advance one clock: model sees pre-edge state and inputs; DUT sampled #1 later.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1; i_sw = 4'b0001; i_button = '0;
    step(); step();
    i_reset = 1'b0;
    checks++; if (o_mode !== 2'd0)     begin errors++; $display("FAIL reset_mode: got %0d exp 0", o_mode); end
    checks++; if (o_led_r !== 4'b0001) begin errors++; $display("FAIL reset_led_r: got %b exp 0001", o_led_r); end
    checks++; if (o_leds !== 4'b0010)  begin errors++; $display("FAIL reset_leds: got %b exp 0010", o_leds); end
    checks++; if ({o_led_g, o_led_b, o_tick} !== 9'b0) begin errors++; $display("FAIL reset_gb_tick: got %b exp 0", {o_led_g, o_led_b, o_tick}); end
  endtask

  task automatic test_shift();
    int pats[$], tks[$];
    int exp_s[4] = '{2, 4, 8, 1};
    logic t;
    for (int i = 0; i < 20; i++) begin
      t = o_tick;
      step();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL shift_vec: got %h exp %h", dut_vec, exp_vec()); end
      if (t) begin pats.push_back(int'(o_led_r)); tks.push_back(i); end
    end
    checks++;
    if (pats.size() < 4) begin errors++; $display("FAIL shift_ticks: got %0d ticks exp >= 4", pats.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (pats[k] != exp_s[k]) begin errors++; $display("FAIL shift_seq%0d: got %0d exp %0d", k, pats[k], exp_s[k]); end
      end
      checks++; if (tks[1] - tks[0] != 4) begin errors++; $display("FAIL shift_period: got %0d exp 4", tks[1] - tks[0]); end
    end
  endtask

  task automatic test_enable();
    logic [3:0] held;
    i_sw = 4'b0001;
    step(); step();
    i_sw = 4'b0000;
    held = 4'(m_pat);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (o_tick !== 1'b0 || o_led_r !== held) begin errors++; $display("FAIL enable_frozen: got tick %b led %b exp tick 0 led %b", o_tick, o_led_r, held); end
    end
    i_sw = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL enable_resume: got %h exp %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_speed();
    i_sw = 4'b0111;
    for (int i = 0; i < 60 && m_cnt != 20; i++) begin
      step();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL speed_vec: got %h exp %h", dut_vec, exp_vec()); end
    end
    checks++; if (m_cnt != 20) begin errors++; $display("FAIL speed_reach: got cnt %0d exp 20", m_cnt); end
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL speed_slow: got %b exp 0", o_tick); end
    i_sw = 4'b0001;
    #1;
    checks++; if (o_tick !== 1'b1) begin errors++; $display("FAIL speed_immediate: got %b exp 1", o_tick); end
    step();
    checks++; if (o_tick !== 1'b0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL speed_after: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_modes();
    int fill_exp[5] = '{1, 3, 7, 15, 0};
    int pats[$];
    logic tog, t;
    i_sw = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tog = o_leds[0];
      i_button = 4'b0001;
      step();
      checks++; if (o_mode !== 2'(k + 1)) begin errors++; $display("FAIL mode_step%0d: got %0d exp %0d", k, o_mode, k + 1); end
      checks++; if (o_leds[0] === tog)    begin errors++; $display("FAIL mode_toggle%0d: got %b exp %b", k, o_leds[0], ~tog); end
      if (k == 0) begin
        checks++; if (o_led_r !== 4'b1111) begin errors++; $display("FAIL flash_seed: got %b exp 1111", o_led_r); end
      end
      if (k == 2) begin
        checks++; if (o_led_r !== 4'b0000) begin errors++; $display("FAIL fill_seed: got %b exp 0000", o_led_r); end
      end
      pats.delete();
      for (int i = 0; i < 30; i++) begin
        if (i == 4) i_button = '0;
        t = o_tick;
        step();
        checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL mode_vec%0d: got %h exp %h", k, dut_vec, exp_vec()); end
        if (t) pats.push_back(int'(o_led_r));
      end
      checks++; if (o_mode !== 2'(k + 1)) begin errors++; $display("FAIL mode_hold%0d: got %0d exp %0d", k, o_mode, k + 1); end
    end
    checks++;
    if (pats.size() < 5) begin errors++; $display("FAIL fill_ticks: got %0d exp >= 5", pats.size()); end
    else for (int k = 0; k < 5; k++) begin
      checks++; if (pats[k] != fill_exp[k]) begin errors++; $display("FAIL fill_seq%0d: got %0d exp %0d", k, pats[k], fill_exp[k]); end
    end
  endtask

  task automatic test_bounce();
    int b_exp[7] = '{2, 4, 8, 4, 2, 1, 2};
    int pats[$];
    logic t;
    i_sw = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      i_button = 4'b0001; step();
      if (k < 2) begin i_button = '0; step(); end
    end
    checks++; if (o_mode !== 2'd2 || o_led_r !== 4'b0001) begin errors++; $display("FAIL bounce_seed: got mode %0d led %b exp 2 0001", o_mode, o_led_r); end
    i_button = '0;
    for (int i = 0; i < 60 && pats.size() < 7; i++) begin
      i_sw[3] = 1'($urandom);
      t = o_tick;
      step();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL bounce_vec: got %h exp %h", dut_vec, exp_vec()); end
      if (t) pats.push_back(int'(o_led_r));
    end
    checks++;
    if (pats.size() < 7) begin errors++; $display("FAIL bounce_ticks: got %0d exp 7", pats.size()); end
    else for (int k = 0; k < 7; k++) begin
      checks++; if (pats[k] != b_exp[k]) begin errors++; $display("FAIL bounce_seq%0d: got %0d exp %0d", k, pats[k], b_exp[k]); end
    end
    i_sw = 4'b0001;
  endtask

  task automatic test_colour();
    i_button = 4'b1000; step(); i_button = '0; step();
    checks++; if (o_leds[3:1] !== 3'b100) begin errors++; $display("FAIL colour_blue: got %b exp 100", o_leds[3:1]); end
    i_button = 4'b1010; step();
    checks++; if (o_leds[3:1] !== 3'b001) begin errors++; $display("FAIL colour_prio: got %b exp 001", o_leds[3:1]); end
    i_button = '0; step();
    i_button = 4'b0100; step();
    checks++; if (o_leds[3:1] !== 3'b010 || o_led_r !== 4'b0 || o_led_g !== 4'(m_pat)) begin
      errors++; $display("FAIL colour_green: got leds %b r %b g %b exp 010 0000 %b", o_leds[3:1], o_led_r, o_led_g, 4'(m_pat));
    end
    i_button = '0; step();
  endtask

  task automatic test_mode_tick();
    int nm;
    for (int i = 0; i < 40 && o_tick !== 1'b1; i++) step();
    checks++;
    if (o_tick !== 1'b1) begin errors++; $display("FAIL mode_tick_wait: got no tick exp tick within 40 cycles"); end
    else begin
      nm = (m_mode + 1) % 4;
      i_button = 4'b0001;
      step();
      checks++; if (o_mode !== 2'(nm) || o_led_g !== 4'(seed(nm))) begin
        errors++; $display("FAIL mode_tick_seed: got mode %0d g %b exp %0d %b", o_mode, o_led_g, nm, 4'(seed(nm)));
      end
      i_button = '0; step();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4 && m_mode != 3; i++) begin
      i_button = 4'b0001; step(); i_button = '0; step();
    end
    for (int i = 0; i < 6; i++) step();
    checks++; if (o_mode !== 2'd3) begin errors++; $display("FAIL rstmid_fill: got %0d exp 3", o_mode); end
    i_reset = 1'b1; i_button = 4'b1111;
    step();
    i_button = '0;
    checks++; if (o_mode !== 2'd0 || o_led_r !== 4'b0001 || o_leds !== 4'b0010 || o_tick !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: got mode %0d r %b leds %b tick %b exp 0 0001 0010 0", o_mode, o_led_r, o_leds, o_tick);
    end
    step();
    i_reset = 1'b0;
    step();
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rstmid_after: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      i_sw = 4'($urandom);
      if ($urandom_range(0, 3) == 0) i_button = 4'($urandom);
      i_reset = ($urandom_range(0, 99) == 0);
      step();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_vec%0d: got %h exp %h", i, dut_vec, exp_vec()); end
    end
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_sw = 4'b0001; i_button = '0;
    test_reset();
    test_shift();
    test_enable();
    test_speed();
    test_modes();
    test_bounce();
    test_colour();
    test_mode_tick();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
